// File: rtl/sigmoid_lut_pkg.sv
// Shared definitions for the programmable sigmoid activation LUT.
//   state_t      : writer FSM states
//   lut_depth    : table depth for a given signed input width
//   offset_index : two's-complement input -> table index (MSB inverted)
package sigmoid_lut_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StActive
    } state_t;

    // Table has one entry per representable input value.
    function automatic int unsigned lut_depth(input int unsigned width);
        return 32'd1 << width;
    endfunction

    // Offset binary: most negative input lands on entry 0, zero on the
    // midpoint, most positive on the last entry. Caller truncates to width.
    function automatic logic [31:0] offset_index(input logic [31:0] value,
                                                 input int unsigned width);
        return value ^ (32'd1 << (width - 1));
    endfunction

endpackage

// File: rtl/lut_ram_sdp.sv
// Simple dual-port table RAM.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address (already registered by the caller)
//   rdata : asynchronous read data
// Contents are deliberately not reset.
module lut_ram_sdp #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEPTH      = 1024,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sigmoid_lut_writer.sv
// Runtime-loadable sigmoid activation table.
// Load side (from the config loader):
//   i_load_start  : restart a full table load at entry 0 (wins over a beat)
//   i_load_valid  : load word valid, accepted while o_load_ready
//   i_load_data   : table word, entries written in order 0..DEPTH-1
//   o_load_ready  : high only while loading
//   o_load_done   : one-cycle pulse after the last entry is written
//   o_table_valid : table complete, lookups enabled
// Lookup side (from the neuron accumulator):
//   i_data_valid  : lookup request
//   i_data_in     : signed lookup input
//   o_data_valid  : result valid, exactly one cycle after the request
//   o_data_out    : table word, forced to 0 when not valid
module sigmoid_lut_writer
    import sigmoid_lut_pkg::*;
#(
    parameter int unsigned DATA_IN_WIDTH  = 10,
    parameter int unsigned DATA_OUT_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      i_load_start,
    input  logic                      i_load_valid,
    input  logic [DATA_OUT_WIDTH-1:0] i_load_data,
    output logic                      o_load_ready,
    output logic                      o_load_done,
    output logic                      o_table_valid,
    input  logic                      i_data_valid,
    input  logic [DATA_IN_WIDTH-1:0]  i_data_in,
    output logic                      o_data_valid,
    output logic [DATA_OUT_WIDTH-1:0] o_data_out
);

    localparam int unsigned DEPTH = lut_depth(DATA_IN_WIDTH);
    localparam logic [DATA_IN_WIDTH-1:0] LAST_ADDR = DATA_IN_WIDTH'(DEPTH - 1);

    state_t                     state_q;
    logic [DATA_IN_WIDTH-1:0]   waddr_q;
    logic                       load_done_q;
    logic                       table_valid_q;
    logic [DATA_IN_WIDTH-1:0]   raddr_q;
    logic                       vld_q;
    logic                       ram_we;
    logic [DATA_OUT_WIDTH-1:0]  ram_rdata;

    // Start discards any coincident beat; reset blocks stray writes too.
    assign ram_we = ~reset & ~i_load_start & (state_q == StLoad) & i_load_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            waddr_q       <= '0;
            load_done_q   <= 1'b0;
            table_valid_q <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            if (i_load_start) begin
                state_q       <= StLoad;
                waddr_q       <= '0;
                table_valid_q <= 1'b0;
            end else begin
                unique case (state_q)
                    StLoad: begin
                        if (i_load_valid) begin
                            if (waddr_q == LAST_ADDR) begin
                                // Address holds at the last entry; no wrap.
                                state_q       <= StActive;
                                table_valid_q <= 1'b1;
                                load_done_q   <= 1'b1;
                            end else begin
                                waddr_q <= waddr_q + 1'b1;
                            end
                        end
                    end
                    StIdle, StActive: ;
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Lookup pipeline: register the mapped address, read asynchronously.
    always_ff @(posedge clk) begin
        if (reset) begin
            raddr_q <= '0;
            vld_q   <= 1'b0;
        end else begin
            raddr_q <= DATA_IN_WIDTH'(offset_index(32'(i_data_in), DATA_IN_WIDTH));
            vld_q   <= i_data_valid & table_valid_q;
        end
    end

    lut_ram_sdp #(
        .DATA_WIDTH (DATA_OUT_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (DATA_IN_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (waddr_q),
        .wdata (i_load_data),
        .raddr (raddr_q),
        .rdata (ram_rdata)
    );

    assign o_load_ready  = (state_q == StLoad);
    assign o_load_done   = load_done_q;
    assign o_table_valid = table_valid_q;
    assign o_data_valid  = vld_q;
    assign o_data_out    = vld_q ? ram_rdata : '0;

endmodule

// File: tb/tb_sigmoid_lut_writer.sv
// Bench for sigmoid_lut_writer with a 4-bit input (16-entry table).
module tb_sigmoid_lut_writer;

    localparam int W    = 4;
    localparam int DW   = 16;
    localparam int N    = 16;
    localparam int HALF = 8;

    logic          clk;
    logic          reset;
    logic          load_start;
    logic          load_valid;
    logic [DW-1:0] load_data;
    logic          load_ready;
    logic          load_done;
    logic          table_valid;
    logic          data_valid;
    logic [W-1:0]  data_in;
    logic          out_valid;
    logic [DW-1:0] data_out;

    int total = 0;
    int bad   = 0;

    // Reference model: table contents plus load progress.
    logic [DW-1:0] m_mem [N];
    bit            m_loading = 0;
    int            m_count   = 0;
    bit            m_tv      = 0;

    sigmoid_lut_writer #(
        .DATA_IN_WIDTH  (W),
        .DATA_OUT_WIDTH (DW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_load_start  (load_start),
        .i_load_valid  (load_valid),
        .i_load_data   (load_data),
        .o_load_ready  (load_ready),
        .o_load_done   (load_done),
        .o_table_valid (table_valid),
        .i_data_valid  (data_valid),
        .i_data_in     (data_in),
        .o_data_valid  (out_valid),
        .o_data_out    (data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: advance the model from the current inputs, clock the DUT,
    // then compare every output 1 time unit after the edge.
    task automatic cycle();
        bit            exp_vld;
        bit            exp_done;
        logic [DW-1:0] exp_out;
        int            idx;
        idx      = int'($signed(data_in)) + HALF;
        exp_vld  = !reset && data_valid && m_tv;
        exp_out  = exp_vld ? m_mem[idx] : '0;
        exp_done = 0;
        if (reset) begin
            m_loading = 0;
            m_count   = 0;
            m_tv      = 0;
        end else if (load_start) begin
            m_loading = 1;
            m_count   = 0;
            m_tv      = 0;
        end else if (m_loading && load_valid) begin
            m_mem[m_count] = load_data;
            m_count++;
            if (m_count == N) begin
                m_loading = 0;
                m_tv      = 1;
                exp_done  = 1;
            end
        end
        @(posedge clk);
        #1;
        check("load_ready", 32'(load_ready), 32'(m_loading));
        check("load_done", 32'(load_done), 32'(exp_done));
        check("table_valid", 32'(table_valid), 32'(m_tv));
        check("data_valid", 32'(out_valid), 32'(exp_vld));
        check("data_out", 32'(data_out), 32'(exp_out));
    endtask

    task automatic idle_inputs();
        reset      = 0;
        load_start = 0;
        load_valid = 0;
        load_data  = '0;
        data_valid = 0;
        data_in    = '0;
    endtask

    task automatic start_load();
        load_start = 1;
        load_valid = 0;
        cycle();
        load_start = 0;
    endtask

    task automatic load_all(input logic [DW-1:0] base);
        for (int k = 0; k < N; k++) begin
            load_valid = 1;
            load_data  = base + DW'(k);
            cycle();
        end
        load_valid = 0;
    endtask

    task automatic lookup(input int value, input string tag, input logic [DW-1:0] exp);
        logic [W-1:0] v;
        v          = W'(value);
        data_valid = 1;
        data_in    = v;
        cycle();
        check(tag, 32'(data_out), 32'(exp));
        check({tag, "_vld"}, 32'(out_valid), 32'd1);
        data_valid = 0;
    endtask

    initial begin
        idle_inputs();

        // Reset for two cycles; a load beat must not be accepted.
        reset      = 1;
        load_valid = 1;
        cycle();
        cycle();
        check("rst_ready", 32'(load_ready), 32'd0);
        check("rst_out", 32'(data_out), 32'd0);
        reset = 0;
        cycle();
        check("idle_ready", 32'(load_ready), 32'd0);
        load_valid = 0;

        // Back-to-back full load; done pulse lands right after beat 15.
        start_load();
        for (int k = 0; k < N; k++) begin
            load_valid = 1;
            load_data  = 16'h1000 + DW'(k);
            cycle();
            if (k == N - 1) begin
                check("done_pulse", 32'(load_done), 32'd1);
                check("tv_rise", 32'(table_valid), 32'd1);
            end else begin
                check("done_early", 32'(load_done), 32'd0);
            end
        end
        load_valid = 0;
        cycle();
        check("done_once", 32'(load_done), 32'd0);

        lookup(-8, "map_m8", 16'h1000);
        lookup(0, "map_0", 16'h1008);
        lookup(7, "map_p7", 16'h100F);

        // Stalled load with random valid gaps and lookups held high.
        start_load();
        data_valid = 1;
        begin
            int acc;
            int budget;
            acc    = 0;
            budget = 0;
            while (acc < N && budget < 400) begin
                load_valid = 1'($urandom_range(0, 1));
                load_data  = load_valid ? 16'h1000 + DW'(acc) : 16'(16'hBAD0 + $urandom_range(0, 15));
                data_in    = W'($urandom_range(0, N - 1));
                cycle();
                if (load_valid) acc++;
                budget++;
            end
            check("stall_bound", 32'(acc), 32'(N));
        end
        load_valid = 0;
        for (int v = -HALF; v < HALF; v++) begin
            lookup(v, "stall_tab", 16'h1000 + DW'(v + HALF));
        end

        // Restart mid-load with a coincident beat, lookups held throughout.
        start_load();
        data_valid = 1;
        data_in    = 4'b1000;
        load_all(16'h4000);
        check("partial_tv", 32'(table_valid), 32'd1);
        start_load();
        for (int k = 0; k < 5; k++) begin
            load_valid = 1;
            load_data  = 16'h4100 + DW'(k);
            cycle();
            check("load_quiet", 32'(out_valid), 32'd0);
        end
        load_start = 1;
        load_valid = 1;
        load_data  = 16'hDEAD;
        cycle();
        load_start = 0;
        load_all(16'h2000);
        lookup(-8, "restart_m8", 16'h2000);
        lookup(7, "restart_p7", 16'h200F);

        // Restart while active: start-cycle lookup completes, next one does not.
        data_valid = 1;
        data_in    = 4'b0000;
        load_start = 1;
        cycle();
        check("restart_hit", 32'(out_valid), 32'd1);
        load_start = 0;
        cycle();
        check("restart_miss", 32'(out_valid), 32'd0);
        load_all(16'h5000);

        // Reset mid-load keeps the table disabled until a full reload.
        start_load();
        load_all(16'h6000);
        start_load();
        load_valid = 1;
        load_data  = 16'h7777;
        cycle();
        reset = 1;
        cycle();
        reset = 0;
        cycle();
        check("rst_mid_tv", 32'(table_valid), 32'd0);
        load_valid = 0;

        // Random traffic over all inputs.
        for (int i = 0; i < 600; i++) begin
            reset      = ($urandom_range(0, 99) == 0);
            load_start = ($urandom_range(0, 59) == 0);
            load_valid = 1'($urandom_range(0, 3) != 0);
            load_data  = 16'($urandom);
            data_valid = 1'($urandom_range(0, 1));
            data_in    = W'($urandom_range(0, N - 1));
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sigmoid_lut_writer.md
Name: sigmoid_lut_writer

Overview:
- Runtime-programmable sigmoid activation table for the MNIST neuron layers.
- It is the writer end of the activation LUT: a controller streams table words in over a valid/ready load port. The block fills the table sequentially, then serves lookups.
- Lookups use the offset-binary indexing and 1-cycle latency the neuron datapath already expects from its activation stage.
- Sits between the weight/config loader (load side) and the neuron accumulator output (lookup side).

Parameters:
- DATA_IN_WIDTH, 10: signed lookup input width; table depth DEPTH = 2**DATA_IN_WIDTH.
- DATA_OUT_WIDTH, 16: table word and lookup output width.

Ports:
- clk  in  1  single clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- i_load_start  in  1  pulse; begin (or restart) a full table load at entry 0.
- i_load_valid  in  1  load word valid.
- i_load_data  in  DATA_OUT_WIDTH  table word; entry order 0..DEPTH-1.
- o_load_ready  out  1  high only in LOAD state.
- o_load_done  out  1  one-cycle pulse when the last entry is written.
- o_table_valid  out  1  table fully loaded, lookups enabled.
- i_data_valid  in  1  lookup request valid.
- i_data_in  in  DATA_IN_WIDTH  signed (two's complement) lookup input.
- o_data_valid  out  1  lookup result valid.
- o_data_out  out  DATA_OUT_WIDTH  sigmoid value; 0 when o_data_valid=0.

Behaviour:
- States: IDLE, LOAD, ACTIVE. Reset: state=IDLE, write address=0, read address register=0.
- Reset values of all outputs: o_load_ready=0, o_load_done=0, o_table_valid=0, o_data_valid=0, o_data_out=0.
- Table RAM contents are not reset. Only o_table_valid qualifies them.
- i_load_start in any state:
  - next state LOAD, write address=0, o_table_valid=0 next cycle.
  - Start has priority: a load beat in the same cycle is discarded and nothing is written.
- LOAD state:
  - o_load_ready=1.
  - Beat accepted when i_load_valid && o_load_ready. It writes mem[waddr] <= i_load_data, then waddr++.
  - Beat accepted with waddr==DEPTH-1: write the entry, then next cycle state=ACTIVE, o_table_valid=1, o_load_done=1 for exactly one cycle.
  - waddr never wraps; no beat is accepted past DEPTH-1.
- IDLE/ACTIVE: o_load_ready=0 and i_load_valid is ignored.
- Index mapping: index = i_data_in with MSB inverted (offset binary).
  - Entry 0 = most negative input (-2**(W-1)).
  - Entry 2**(W-1) = input 0.
  - Entry DEPTH-1 = most positive input.
- Lookup pipeline:
  - Every cycle: raddr_q <= mapped index of i_data_in, vld_q <= i_data_valid && o_table_valid.
  - o_data_valid = vld_q; o_data_out = vld_q ? mem[raddr_q] : 0.
  - Latency exactly 1 cycle, throughput 1 per cycle, no backpressure.
- Read/write in the same cycle cannot occur. Lookups are suppressed whenever o_table_valid=0, including all of LOAD.
- Reset mid-load: returns to IDLE with o_table_valid=0. Partially written entries remain but are unusable until a full reload completes.
- Restart (i_load_start) while ACTIVE: o_table_valid drops the next cycle. A lookup issued in the start cycle still completes; one issued the following cycle does not.

Decomposition:
- Package sigmoid_lut_pkg holds:
  - state enum {IDLE, LOAD, ACTIVE};
  - a function computing DEPTH from DATA_IN_WIDTH;
  - an MSB-invert index-mapping function shared with the neuron testbench model.
- One sub-module, lut_ram_sdp: simple dual-port RAM, synchronous write port, asynchronous read from the registered address. Width and depth are parameterised.

Test Plan:
All scenarios use DATA_IN_WIDTH=4 (DEPTH=16), DATA_OUT_WIDTH=16.
- Reset: assert reset for 2 cycles -> all outputs 0, state IDLE; i_load_valid=1 gives o_load_ready=0.
- Full load: i_load_start, then 16 back-to-back beats data=0x1000+k -> o_load_done pulses once, 1 cycle after beat 15; o_table_valid=1 that same cycle.
- Lookup mapping: inputs 4'b1000 (-8), 4'b0000 (0), 4'b0111 (+7) -> o_data_out 0x1000, 0x1008, 0x100F, each 1 cycle after its input, with o_data_valid=1.
- Stalled load: i_load_valid toggled 50% during the load -> only accepted beats write; completion after the 16th accepted beat; table contents identical to the back-to-back case.
- Restart mid-load: after 5 beats assert i_load_start together with a valid beat -> that beat is dropped, waddr=0. Then 16 beats of 0x2000+k -> lookup of -8 returns 0x2000.
- Lookup during load: i_data_valid=1 throughout LOAD -> o_data_valid=0 and o_data_out=0 every cycle until o_table_valid rises.
